// File: rtl/timer_ctrl_pkg.sv
// Shared types and constants for the timer front-panel controller.
// Holds the FSM state encoding, default timing params and zero count.
package timer_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUNNING = 2'd1,
      PAUSED  = 2'd2,
      EXPIRED = 2'd3
   } timer_state_t;

   localparam int unsigned DB_CYCLES_DEFAULT    = 2;
   localparam int unsigned ALARM_CYCLES_DEFAULT = 300;

   localparam logic [15:0] COUNT_ZERO = 16'h0000;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter, rise event.
// Ports: clk, rst_n, raw (async in), level (accepted), evt (1-cycle rise).
module btn_debounce
   import timer_ctrl_pkg::*;
#(
   parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic evt
);

   localparam logic [7:0] CNT_LAST = 8'(DB_CYCLES - 1);

   logic       sync1;
   logic       sync2;
   logic [7:0] cnt;

   // cnt holds how many consecutive cycles sync2 has disagreed with
   // level, minus one on the accepting cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         cnt   <= 8'd0;
         level <= 1'b0;
         evt   <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         evt   <= 1'b0;
         if (sync2 == level) begin
            cnt <= 8'd0;
         end else if (cnt == CNT_LAST) begin
            cnt   <= 8'd0;
            level <= sync2;
            evt   <= sync2;
         end else begin
            cnt <= cnt + 8'd1;
         end
      end
   end

endmodule

// File: rtl/timer_mode_controller.sv
// Front-panel FSM for the two-mode timer core: buttons, expiry, alarm.
// Ports: clk, rst_n, three raw buttons, core count in; StartStop,
// ModeSel, core_rst_n, alarm, state out. Alarm counter is built only
// when TIMER_ALARM_EN is defined; otherwise alarm is tied low.
module timer_mode_controller
   import timer_ctrl_pkg::*;
#(
   parameter int unsigned DB_CYCLES    = DB_CYCLES_DEFAULT,
   parameter int unsigned ALARM_CYCLES = ALARM_CYCLES_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_startstop_raw,
   input  logic       btn_mode_raw,
   input  logic       btn_clear_raw,
   input  logic [7:0] core_msb,
   input  logic [7:0] core_lsb,
   output logic       StartStop,
   output logic       ModeSel,
   output logic       core_rst_n,
   output logic       alarm,
   output logic [1:0] state
);

   logic ss_evt;
   logic mode_evt;
   logic clr_evt;
   logic [2:0] unused_lvl;

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_ss (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_startstop_raw),
      .level (unused_lvl[0]),
      .evt   (ss_evt)
   );

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_mode_raw),
      .level (unused_lvl[1]),
      .evt   (mode_evt)
   );

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_clear_raw),
      .level (unused_lvl[2]),
      .evt   (clr_evt)
   );

   timer_state_t st;
   timer_state_t st_nxt;
   logic         mode_q;
   logic         mode_nxt;
   logic         ss_nxt;
   logic         clr_nxt;
   logic         alarm_load;
   logic         count_zero;
   logic         expiry;

   assign count_zero = ({core_msb, core_lsb} == COUNT_ZERO);
   assign expiry     = mode_q & count_zero;

   // Each branch applies only the highest-priority event that the
   // state honours; lower ones are simply dropped.
   always_comb begin
      st_nxt     = st;
      mode_nxt   = mode_q;
      ss_nxt     = 1'b0;
      clr_nxt    = 1'b0;
      alarm_load = 1'b0;
      unique case (st)
         IDLE: begin
            if (clr_evt) begin
               clr_nxt = 1'b1;
            end else if (ss_evt) begin
               st_nxt = RUNNING;
               ss_nxt = 1'b1;
            end else if (mode_evt) begin
               mode_nxt = ~mode_q;
               clr_nxt  = 1'b1;
            end
         end
         RUNNING: begin
            if (expiry) begin
               st_nxt     = EXPIRED;
               ss_nxt     = 1'b1;
               alarm_load = 1'b1;
            end else if (ss_evt) begin
               st_nxt = PAUSED;
               ss_nxt = 1'b1;
            end
         end
         PAUSED: begin
            if (clr_evt) begin
               st_nxt  = IDLE;
               clr_nxt = 1'b1;
            end else if (ss_evt) begin
               st_nxt = RUNNING;
               ss_nxt = 1'b1;
            end else if (mode_evt) begin
               st_nxt   = IDLE;
               mode_nxt = ~mode_q;
               clr_nxt  = 1'b1;
            end
         end
         EXPIRED: begin
            if (clr_evt) begin
               st_nxt  = IDLE;
               clr_nxt = 1'b1;
            end
         end
         default: st_nxt = IDLE;
      endcase
   end

   logic ss_q;
   logic crst_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st     <= IDLE;
         mode_q <= 1'b0;
         ss_q   <= 1'b0;
         crst_q <= 1'b1;
      end else begin
         st     <= st_nxt;
         mode_q <= mode_nxt;
         ss_q   <= ss_nxt;
         crst_q <= ~clr_nxt;
      end
   end

   assign state      = st;
   assign ModeSel    = mode_q;
   assign StartStop  = ss_q;
   assign core_rst_n = crst_q;

`ifdef TIMER_ALARM_EN
   localparam logic [15:0] ALARM_LAST = 16'(ALARM_CYCLES - 1);

   logic [15:0] alarm_cnt;
   logic        alarm_q;

   // alarm_cnt counts the remaining high cycles after the current one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alarm_q   <= 1'b0;
         alarm_cnt <= 16'd0;
      end else if (alarm_load) begin
         alarm_q   <= 1'b1;
         alarm_cnt <= ALARM_LAST;
      end else if (st_nxt != EXPIRED) begin
         alarm_q   <= 1'b0;
         alarm_cnt <= 16'd0;
      end else if (alarm_q) begin
         if (alarm_cnt == 16'd0) begin
            alarm_q <= 1'b0;
         end else begin
            alarm_cnt <= alarm_cnt - 16'd1;
         end
      end
   end

   assign alarm = alarm_q;
`else
   logic [16:0] unused_alarm;

   assign unused_alarm = {alarm_load, 16'(ALARM_CYCLES)};
   assign alarm        = 1'b0;
`endif

endmodule

// File: doc/timer_mode_controller.md
# timer_mode_controller

Front-panel controller for the two-mode timer core. Debounces the three raw panel buttons (start/stop, mode, clear) and runs an IDLE/RUNNING/PAUSED/EXPIRED state machine. It drives the core's `StartStop`, `ModeSel` and clear, and watches the core's count outputs to detect countdown expiry and raise an alarm. Sits between the board-level button pins and the timer core, in the same 100 Hz clock domain.

## Interface
- `DB_CYCLES`, 2: cycles a synchronised button level must be stable before acceptance (20 ms at 100 Hz); legal range 1..255.
- `ALARM_CYCLES`, 300: cycles `alarm` stays high after expiry (3 s at 100 Hz); legal range 1..65535.

- `clk` in 1: system clock (100 Hz on silicon).
- `rst_n` in 1: asynchronous, active-low reset.
- `btn_startstop_raw` in 1: raw start/stop button, active-high, asynchronous.
- `btn_mode_raw` in 1: raw mode button, active-high, asynchronous.
- `btn_clear_raw` in 1: raw clear button, active-high, asynchronous.
- `core_msb` in 8: core `MSBbinaryout`.
- `core_lsb` in 8: core `LSBbinaryout`.
- `StartStop` out 1: one-cycle toggle pulse to the core.
- `ModeSel` out 1: 0 = stopwatch, 1 = countdown (from 2:00).
- `core_rst_n` out 1: active-low clear to the core; one-cycle low pulse.
- `alarm` out 1: countdown-expired indicator.
- `state` out 2: current FSM state, for display and debug.

## Operation
- Each button passes through a `btn_debounce` instance:
  - 2-flop synchroniser.
  - Stability counter; the accepted level changes only after the synchronised level differs from it for `DB_CYCLES` consecutive cycles.
  - One-cycle `evt` on each accepted 0→1 transition.
- States (package encoding): IDLE=0, RUNNING=1, PAUSED=2, EXPIRED=3.
- Event priority when several events occur in the same cycle: clear > expiry > start/stop > mode. Only the highest-priority applicable event acts; the others are dropped, not queued.
- IDLE:
  - start/stop → RUNNING, pulse `StartStop`.
  - mode → toggle `ModeSel`, pulse `core_rst_n`, stay IDLE.
  - clear → pulse `core_rst_n`, stay IDLE.
- RUNNING:
  - start/stop → PAUSED, pulse `StartStop`.
  - mode and clear are ignored.
  - Expiry: `ModeSel`=1 and {`core_msb`,`core_lsb`}==0 → EXPIRED, pulse `StartStop` to halt the core, load the alarm counter.
- PAUSED:
  - start/stop → RUNNING, pulse `StartStop`.
  - clear → IDLE, pulse `core_rst_n`.
  - mode → IDLE, toggle `ModeSel`, pulse `core_rst_n`.
- EXPIRED:
  - start/stop and mode are ignored.
  - clear → IDLE, pulse `core_rst_n`, `alarm` drops immediately.
- Expiry is never evaluated in stopwatch mode (`ModeSel`=0), or in any state other than RUNNING.
- `alarm` is high from EXPIRED entry for exactly `ALARM_CYCLES` cycles, or until clear, whichever is first. State remains EXPIRED after `alarm` drops.

## Timing
- Reset values: `StartStop`=0, `ModeSel`=0, `core_rst_n`=1, `alarm`=0, `state`=IDLE. Debounce levels=0, counters=0.
- Reset asserted mid-operation returns all outputs to the reset values asynchronously. No `StartStop` or `core_rst_n` pulse is issued on reset release.
- Button latency: a raw rise held stable produces `evt` at cycle 2+`DB_CYCLES`. The FSM state and output pulse appear registered on the following cycle. Total latency is `DB_CYCLES`+3 cycles (5 with defaults).
- Glitches shorter than `DB_CYCLES` cycles after synchronisation produce no event.
- A held button produces exactly one event; release is debounced the same way.
- Expiry latency: the zero count is sampled at cycle N; `state`=EXPIRED, `StartStop`=1 and `alarm`=1 at cycle N+1.
- `StartStop` and `core_rst_n` pulses are exactly one cycle wide. They are never asserted in the same cycle.
- `ModeSel` changes in the same cycle as the `core_rst_n` low pulse.

## Configuration
- `TIMER_ALARM_EN` defined: the alarm counter is built and `alarm` behaves as specified.
- `TIMER_ALARM_EN` undefined:
  - No alarm counter is built and `alarm` is tied to 0.
  - The FSM, including the EXPIRED state and its stop pulse, is unchanged.

## Structure
- Package `timer_ctrl_pkg`:
  - state enum `timer_state_t` (2 bits, encodings above);
  - localparams `DB_CYCLES_DEFAULT`=2 and `ALARM_CYCLES_DEFAULT`=300;
  - localparam `COUNT_ZERO`=16'h0000.
- Sub-module `btn_debounce` (ports `clk`, `rst_n`, `raw`, `level`, `evt`; parameter `DB_CYCLES`), instantiated three times.
- Top level holds the FSM, the zero detect and the alarm counter.

## Test plan
- Reset, then press start/stop (held 10 cycles) → `StartStop` pulse 5 cycles after the raw rise; `state`=RUNNING. Press again → second pulse; `state`=PAUSED.
- 1-cycle glitch on `btn_startstop_raw` in IDLE → no `StartStop` pulse; `state` stays IDLE.
- IDLE, press mode → `ModeSel`=1 and a one-cycle `core_rst_n` low. Press mode while RUNNING → no change.
- `ModeSel`=1, RUNNING, drive `core_msb`=0 and `core_lsb`=0 → next cycle `state`=EXPIRED, `StartStop` pulse, `alarm`=1 for 300 cycles. Clear at cycle 100 → `alarm`=0 and `state`=IDLE next cycle.
- Clear and start/stop raw edges simultaneous in PAUSED → `state`=IDLE, `core_rst_n` pulse, no `StartStop` pulse.
- `rst_n` low while EXPIRED with `alarm`=1 → all outputs at reset values immediately; no pulses after release.
